// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] instr;
  logic                  eq;
  logic                  dmem_ready;
  logic                  pc_en;
  logic                  pc_src;
  logic                  reg_write;
  logic                  alu_src;
  logic [2:0]            alu_ctrl;
  logic [12:0]           imm_out;
  logic                  imm_src;
  logic                  dmem_req;
  logic                  mem_write;
  logic                  result_src;
  logic                  illegal;
  logic [2:0]            state_o;

  modport master (
    input  instr, eq, dmem_ready,
    output pc_en, pc_src, reg_write, alu_src, alu_ctrl, imm_out, imm_src,
           dmem_req, mem_write, result_src, illegal, state_o
  );

  modport slave (
    output instr, eq, dmem_ready,
    input  pc_en, pc_src, reg_write, alu_src, alu_ctrl, imm_out, imm_src,
           dmem_req, mem_write, result_src, illegal, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller (addi/add/bne/lw/sw).
// Define ILLEGAL_HALT_EN to halt on illegal opcodes; otherwise they retire as NOPs.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_if.master     bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB_ALU = 3'd3;
  localparam logic [2:0] S_BRANCH = 3'd4;
  localparam logic [2:0] S_MEMADR = 3'd5;
  localparam logic [2:0] S_MEM    = 3'd6;
  localparam logic [2:0] S_WB_MEM = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic [2:0]  state, state_nxt;
  logic [31:0] ir;
  logic        halted;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_addi, is_add, is_bne, is_lw, is_sw, is_alu, is_mem, legal;
  logic       unused_rs1;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];
  // rs1 field is consumed by the datapath only
  assign unused_rs1 = ^ir[19:15];

  assign is_addi = (opc == OP_IMM)    && (f3 == 3'b000);
  assign is_add  = (opc == OP_REG)    && (f3 == 3'b000) && (f7 == 7'd0);
  assign is_bne  = (opc == OP_BRANCH) && (f3 == 3'b001);
  assign is_lw   = (opc == OP_LOAD)   && (f3 == 3'b010);
  assign is_sw   = (opc == OP_STORE)  && (f3 == 3'b010);
  assign is_alu  = is_addi | is_add;
  assign is_mem  = is_lw | is_sw;
  assign legal   = is_alu | is_bne | is_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) ir <= bus.instr[31:0];
    end
  end

`ifdef ILLEGAL_HALT_EN
  logic ill_q;
  // HALT shares code 7 with WB_MEM; the sticky flag tells them apart
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                ill_q <= 1'b0;
    else if (state == S_DECODE && !legal)    ill_q <= 1'b1;
  end
  assign halted = ill_q;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_alu)      state_nxt = S_EXEC;
        else if (is_bne) state_nxt = S_BRANCH;
        else if (is_mem) state_nxt = S_MEMADR;
`ifdef ILLEGAL_HALT_EN
        else             state_nxt = S_WB_MEM;
`else
        else             state_nxt = S_FETCH;
`endif
      end
      S_EXEC:   state_nxt = S_WB_ALU;
      S_WB_ALU: state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_MEMADR: state_nxt = S_MEM;
      S_MEM:    if (bus.dmem_ready) state_nxt = is_sw ? S_FETCH : S_WB_MEM;
      S_WB_MEM: state_nxt = halted ? S_WB_MEM : S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    bus.imm_out = '0;
    bus.imm_src = 1'b0;
    case (opc)
      OP_IMM, OP_LOAD: begin
        bus.imm_out = {ir[31], ir[31:20]};
        bus.imm_src = 1'b1;
      end
      OP_STORE: begin
        bus.imm_out = {ir[31], ir[31:25], ir[11:7]};
        bus.imm_src = 1'b1;
      end
      OP_BRANCH: begin
        bus.imm_out = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        bus.imm_src = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.pc_en      = 1'b0;
    bus.pc_src     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src    = 1'b0;
    bus.alu_ctrl   = 3'b000;
    bus.dmem_req   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.result_src = 1'b0;
    case (state)
`ifndef ILLEGAL_HALT_EN
      S_DECODE: bus.pc_en = !legal;
`endif
      S_EXEC:   bus.alu_src = is_addi;
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.pc_en     = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_ctrl = 3'b001;
        bus.pc_en    = 1'b1;
        bus.pc_src   = !bus.eq;
      end
      S_MEMADR: bus.alu_src = 1'b1;
      S_MEM: begin
        bus.dmem_req  = 1'b1;
        bus.mem_write = is_sw;
        bus.pc_en     = is_sw & bus.dmem_ready;
      end
      S_WB_MEM: if (!halted) begin
        bus.reg_write  = 1'b1;
        bus.result_src = 1'b1;
        bus.pc_en      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.illegal = halted;
  assign bus.state_o = state;

endmodule
